dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 37 +++
 rtl/dmem_arb_rr.sv | 32 +++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   state_t    : arbiter FSM states (IDLE / ACCESS / RESP)
//   port_idx_t : index of a requester port (0 or 1)
//   cmd_t      : command register contents latched at grant
//   addr_legal : word-aligned, in-range address check
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_idx_t;

  // Low address bits that must be zero for a word access, and the shift
  // that turns a byte address into a word index.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;
  localparam int unsigned WORD_SHIFT      = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // An access is legal when it is word aligned and its word index falls
  // inside the attached memory.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned mem_words);
    return ((addr & WORD_ALIGN_MASK) == 32'h0) && ((addr >> WORD_SHIFT) < mem_words);
  endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// ---------------------------------------------------------------------------
// dmem_arb_rr
// Two-way round-robin pick. A lone requester wins; on contention the port
// that was not granted last wins.
//   req0, req1  : request inputs of port 0 and port 1
//   last        : port granted most recently
//   grant_valid : at least one request is present
//   grant_idx   : winning port (meaningful only when grant_valid=1)
// ---------------------------------------------------------------------------
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last,
  output logic      grant_valid,
  output port_idx_t grant_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates two load/store requesters onto one single-port data memory.
// Each access takes IDLE (grant) -> ACCESS (memory cycle) -> RESP (ack),
// so a request sampled at edge N is acknowledged two edges later.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_p, we_p           : request and store/load select, p in {0,1}
//   addr_p, wdata_p       : byte address and store data, p in {0,1}
//   ack_p, err_p, rdata_p : one-cycle completion pulse with error flag and
//                           load data, p in {0,1}
//   mem_read, mem_write   : memory strobes, only in ACCESS for legal accesses
//   mem_addr, mem_wdata   : memory address / write data, zero outside ACCESS
//   mem_rdata             : combinational read data from the memory
//   busy                  : FSM is not in IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        we_0,
  input  logic [31:0] addr_0,
  input  logic [31:0] wdata_0,
  output logic        ack_0,
  output logic        err_0,
  output logic [31:0] rdata_0,
  input  logic        req_1,
  input  logic        we_1,
  input  logic [31:0] addr_1,
  input  logic [31:0] wdata_1,
  output logic        ack_1,
  output logic        err_1,
  output logic [31:0] rdata_1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_t    state;
  port_idx_t last;      // most recent grant; also the port served right now
  cmd_t      cmd;

  logic      grant_valid;
  port_idx_t grant_idx;
  logic      in_access;
  logic      cmd_legal;
  logic [31:0] resp_rdata;

  dmem_arb_rr u_rr (
    .req0        (req_0),
    .req1        (req_1),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign in_access = (state == ACCESS);
  assign cmd_legal = addr_legal(cmd.addr, MEM_WORDS);

  // Memory side is a gated view of the command register, so it is quiet in
  // every state but ACCESS and the strobes never fire for an illegal access.
  assign mem_read  = in_access & cmd_legal & ~cmd.we;
  assign mem_write = in_access & cmd_legal &  cmd.we;
  assign mem_addr  = in_access ? cmd.addr  : 32'h0;
  assign mem_wdata = in_access ? cmd.wdata : 32'h0;

  // Stores and illegal accesses return zero data.
  assign resp_rdata = (cmd_legal && !cmd.we) ? mem_rdata : 32'h0;

  assign busy = (state != IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every update in this block sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      cmd     <= '0;
      ack_0   <= 1'b0;
      err_0   <= 1'b0;
      rdata_0 <= 32'h0;
      ack_1   <= 1'b0;
      err_1   <= 1'b0;
      rdata_1 <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last  <= grant_idx;
            cmd   <= (grant_idx == 1'b1) ? cmd_t'{we: we_1, addr: addr_1, wdata: wdata_1}
                                         : cmd_t'{we: we_0, addr: addr_0, wdata: wdata_0};
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // Capture the memory response for the port being served; it is
          // presented together with ack during RESP.
          if (last == 1'b0) begin
            ack_0   <= 1'b1;
            err_0   <= ~cmd_legal;
            rdata_0 <= resp_rdata;
          end else begin
            ack_1   <= 1'b1;
            err_1   <= ~cmd_legal;
            rdata_1 <= resp_rdata;
          end
          state <= RESP;
        end
        RESP: begin
          // Requests are ignored here; a held req is re-sampled in IDLE.
          ack_0   <= 1'b0;
          err_0   <= 1'b0;
          rdata_0 <= 32'h0;
          ack_1   <= 1'b0;
          err_1   <= 1'b0;
          rdata_1 <= 32'h0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a table of single-port transactions
// plus hand-written sequences for contention, held requests and reset abort.
// Expected responses go into a scoreboard queue when a request is driven and
// are popped by a monitor whenever an ack appears.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, we_0, req_1, we_1;
  logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
  logic        ack_0, err_0, ack_1, err_1;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_0     (req_0),
    .we_0      (we_0),
    .addr_0    (addr_0),
    .wdata_0   (wdata_0),
    .ack_0     (ack_0),
    .err_0     (err_0),
    .rdata_0   (rdata_0),
    .req_1     (req_1),
    .we_1      (we_1),
    .addr_1    (addr_1),
    .wdata_1   (wdata_1),
    .ack_1     (ack_1),
    .err_1     (err_1),
    .rdata_1   (rdata_1),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: every word holds a recognisable non-zero pattern after
  // reset so leaked read data on illegal accesses is visible.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected acks.
  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Memory strobe bookkeeping for the transaction in flight.
  int          n_rd, n_wr;
  logic [31:0] strobe_addr, strobe_wdata;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_read)  begin n_rd++; strobe_addr = mem_addr; end
      if (mem_write) begin n_wr++; strobe_addr = mem_addr; strobe_wdata = mem_wdata; end
      if (!busy) begin
        check("idle_mem_quiet", {31'b0, mem_read | mem_write, mem_addr | mem_wdata}, 64'h0);
      end
      if (ack_0 || ack_1) begin
        check("ack_onehot", 64'(ack_0 & ack_1), 64'h0);
        if (sb.size() == 0) begin
          check("unexpected_ack", {62'b0, ack_1, ack_0}, 64'h0);
        end else begin
          e = sb.pop_front();
          check("ack_port", 64'(ack_1), 64'(e.port));
          check("ack_err", 64'(ack_1 ? err_1 : err_0), 64'(e.err));
          check("ack_rdata", 64'(ack_1 ? rdata_1 : rdata_0), 64'(e.rdata));
          check("other_port_quiet", ack_1 ? {31'b0, err_0, rdata_0} : {31'b0, err_1, rdata_1}, 64'h0);
        end
      end
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[11];

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      req_0 = req; we_0 = we; addr_0 = addr; wdata_0 = wdata;
    end else begin
      req_1 = req; we_1 = we; addr_1 = addr; wdata_1 = wdata;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One single-port transaction: drive, wait (bounded) for the ack, check
  // its latency and the memory strobes it produced.
  task automatic do_txn(input vec_t v);
    int k;
    bit got;
    bit legal;
    @(negedge clk);
    n_rd = 0;
    n_wr = 0;
    sb.push_back('{port: v.port, err: v.exp_err, rdata: v.exp_rdata});
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    k = 0;
    got = 1'b0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      got = (v.port == 1'b0) ? ack_0 : ack_1;
    end
    check("txn_latency", 64'(k), 64'd2);
    if (!got) sb.delete();
    drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    legal = !v.exp_err;
    check("rd_strobes", 64'(n_rd), 64'(legal && !v.we));
    check("wr_strobes", 64'(n_wr), 64'(legal && v.we));
    if (legal) check("strobe_addr", 64'(strobe_addr), 64'(v.addr));
    if (legal && v.we) check("strobe_wdata", 64'(strobe_wdata), 64'(v.wdata));
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;

    vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 0, 32'h0000_0402, 32'h0,         1, 32'h0};
    vecs[3]  = '{1, 0, 32'h0000_0400, 32'h0,         1, 32'h0};
    vecs[4]  = '{0, 1, 32'h0000_03FC, 32'hCAFE_F00D, 0, 32'h0};
    vecs[5]  = '{0, 0, 32'h0000_03FC, 32'h0,         0, 32'hCAFE_F00D};
    vecs[6]  = '{1, 0, 32'h0000_0020, 32'h0,         0, 32'hA500_0008};
    vecs[7]  = '{1, 1, 32'h0000_0401, 32'h1111_1111, 1, 32'h0};
    vecs[8]  = '{1, 0, 32'h0000_0000, 32'h0,         0, 32'hA500_0000};
    vecs[9]  = '{0, 1, 32'h0000_03FD, 32'h2222_2222, 1, 32'h0};
    vecs[10] = '{1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    // Reset state, while reset is still asserted.
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_acks", {62'b0, ack_1, ack_0}, 64'h0);
    check("rst_errs", {62'b0, err_1, err_0}, 64'h0);
    check("rst_rdata", {rdata_1, rdata_0}, 64'h0);
    check("rst_mem_strobes", {62'b0, mem_write, mem_read}, 64'h0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 64'h0);
    rst_n = 1'b1;

    // Single-port transactions from the table.
    for (int i = 0; i < 11; i++) do_txn(vecs[i]);

    // Contention right after reset: both held, grants 0,1,0,1 every 3 cycles.
    apply_reset();
    sb.push_back('{port: 0, err: 0, rdata: 32'hA500_0010});
    sb.push_back('{port: 1, err: 0, rdata: 32'hA500_0011});
    sb.push_back('{port: 0, err: 0, rdata: 32'hA500_0010});
    sb.push_back('{port: 1, err: 0, rdata: 32'hA500_0011});
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("rr_ack0_k%0d", k), 64'(ack_0), 64'(k == 2 || k == 8));
      check($sformatf("rr_ack1_k%0d", k), 64'(ack_1), 64'(k == 5 || k == 11));
      check($sformatf("rr_busy_k%0d", k), 64'(busy), 64'(k % 3 != 0));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rr_sb_drained", 64'(sb.size()), 64'h0);

    // Request held across its ack: next ACCESS two cycles after the ack.
    @(negedge clk);
    sb.push_back('{port: 0, err: 0, rdata: 32'hA500_0002});
    sb.push_back('{port: 0, err: 0, rdata: 32'hA500_0002});
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("hold_ack0_k%0d", k), 64'(ack_0), 64'(k == 2 || k == 5));
      check($sformatf("hold_rd_k%0d", k), 64'(mem_read), 64'(k == 1 || k == 4));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("hold_sb_drained", 64'(sb.size()), 64'h0);

    // Reset during the ACCESS of a port-1 store aborts it without an ack.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    check("abort_pre_write", 64'(mem_write), 64'h1);
    check("abort_pre_busy", 64'(busy), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_strobes", {62'b0, mem_write, mem_read}, 64'h0);
    check("abort_acks", {62'b0, ack_1, ack_0}, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_ack", 64'(sb.size()), 64'h0);

    // Next contention after the abort must grant port 0 first.
    sb.push_back('{port: 0, err: 0, rdata: 32'hA500_0010});
    sb.push_back('{port: 1, err: 0, rdata: 32'hA500_0011});
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("post_abort_sb_drained", 64'(sb.size()), 64'h0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
